// File: rtl/alu_operand_issue.sv
// alu_operand_issue: small command FIFO in front of the 8-bit ALU.
// Legal commands are queued and presented one at a time to the ALU;
// illegal opcodes are consumed, dropped and counted. NOT commands have
// their unused B operand zeroed so the ALU B input does not toggle.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge
// when valid && ready are both high. in_ready depends only on stored
// state (level != DEPTH), so there is no combinational path from
// out_ready to in_ready; a full queue does not accept a push even if the
// head is popped in the same cycle. out_valid is high exactly when the
// queue holds an entry, and the head fields are stable until popped.
module alu_operand_issue #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_alu_op,
    input  logic [DATA_W-1:0]        in_op_a,
    input  logic [DATA_W-1:0]        in_op_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          alu_op,
    output logic [DATA_W-1:0]        op_a,
    output logic [DATA_W-1:0]        op_b,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // Highest legal opcode is NOT (101); 110 and 111 are illegal.
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(5);

    logic [OP_W-1:0]   op_mem_q [DEPTH];
    logic [DATA_W-1:0] a_mem_q  [DEPTH];
    logic [DATA_W-1:0] b_mem_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

    logic              cmd_legal;
    logic              push_hs;
    logic              push_legal;
    logic              push_illegal;
    logic              pop_hs;
    logic [DATA_W-1:0] b_store;

    assign in_ready     = (level_q != LVL_W'(DEPTH));
    assign out_valid    = (level_q != '0);
    assign cmd_legal    = (in_alu_op <= OP_NOT);
    assign push_hs      = in_valid && in_ready;
    assign push_legal   = push_hs && cmd_legal;
    assign push_illegal = push_hs && !cmd_legal;
    assign pop_hs       = out_valid && out_ready;
    assign b_store      = (in_alu_op == OP_NOT) ? '0 : in_op_b;

    // Head presentation; driven to zero when nothing is stored.
    assign alu_op      = out_valid ? op_mem_q[rd_ptr_q] : '0;
    assign op_a        = out_valid ? a_mem_q[rd_ptr_q]  : '0;
    assign op_b        = out_valid ? b_mem_q[rd_ptr_q]  : '0;
    assign level       = level_q;
    assign illegal_cnt = illegal_cnt_q;

    // Next-state for pointers, level and illegal counter; flush wins over push/pop.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_legal) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_hs) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_legal, pop_hs})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (push_illegal && (illegal_cnt_q != '1)) begin
                illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
        end
    end

    // State register; reset overrides flush and everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            illegal_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Entry storage; written only on an accepted legal push that is not flushed.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_legal) begin
            op_mem_q[wr_ptr_q] <= in_alu_op;
            a_mem_q[wr_ptr_q]  <= in_op_a;
            b_mem_q[wr_ptr_q]  <= b_store;
        end
    end

endmodule
